// File: rtl/access_ctrl_param.sv
// Parking-access controller: PIN check against a key table, attempt lockout,
// tailgate detection and lot occupancy tracking. All outputs are registered.
module access_ctrl_param #(
  parameter int unsigned                   CLAVE_W        = 16,
  parameter int unsigned                   NUM_CLAVES     = 2,
  parameter logic [NUM_CLAVES*CLAVE_W-1:0] CLAVES         = {16'h1234, 16'hBEEF},
  parameter int unsigned                   MAX_INTENTOS   = 3,
  parameter int unsigned                   CAPACIDAD      = 8,
  parameter int unsigned                   TIMEOUT_CICLOS = 1000,
  parameter int unsigned                   OCC_W          = $clog2(CAPACIDAD + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sensor_llegada_vehiculo,
  input  logic               sensor_ingreso_vehiculo,
  input  logic               sensor_salida_vehiculo,
  input  logic               clave_enter,
  input  logic [CLAVE_W-1:0] clave_ingresada,
  output logic               senal_compuerta,
  output logic               senal_alarma_pin,
  output logic               senal_alarma_bloqueo,
  output logic               senal_lleno,
  output logic [OCC_W-1:0]   ocupacion
);

  localparam int unsigned INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CICLOS + 1);

  localparam logic [INT_W-1:0] MaxIntentos   = INT_W'(MAX_INTENTOS);
  localparam logic [TO_W-1:0]  TimeoutCiclos = TO_W'(TIMEOUT_CICLOS);
  localparam logic [OCC_W-1:0] CapOcc        = OCC_W'(CAPACIDAD);

  typedef enum logic [1:0] {StIdle, StEsperaClave, StAbierta, StBloqueo} state_e;

  state_e           state_q, state_d;
  logic [INT_W-1:0] intentos_q, intentos_d, intentos_inc;
  logic [TO_W-1:0]  timeout_q, timeout_d, timeout_inc;
  logic [OCC_W-1:0] ocupacion_q, ocupacion_d;
  logic             alarma_pin_q, alarma_pin_d;
  logic             compuerta_q, alarma_bloqueo_q, lleno_q;
  logic             salida_prev_q;
  logic             match, inc, dec;

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_CLAVES; i++) begin
      if (clave_ingresada == CLAVES[i*CLAVE_W +: CLAVE_W]) match = 1'b1;
    end
  end

  assign intentos_inc = intentos_q + INT_W'(1);
  assign timeout_inc  = timeout_q + TO_W'(1);

  always_comb begin
    state_d      = state_q;
    intentos_d   = intentos_q;
    timeout_d    = timeout_q;
    alarma_pin_d = alarma_pin_q;
    inc          = 1'b0;
    unique case (state_q)
      StIdle: begin
        alarma_pin_d = 1'b0;
        if (sensor_llegada_vehiculo && !lleno_q) begin
          state_d    = StEsperaClave;
          intentos_d = '0;
          timeout_d  = '0;
        end
      end
      StEsperaClave: begin
        if (clave_enter) begin
          timeout_d = '0;
          if (match) begin
            state_d      = StAbierta;
            intentos_d   = '0;
            alarma_pin_d = 1'b0;
          end else begin
            intentos_d   = intentos_inc;
            alarma_pin_d = 1'b1;
            if (intentos_inc == MaxIntentos) state_d = StBloqueo;
          end
        end else if (timeout_inc == TimeoutCiclos) begin
          state_d      = StIdle;
          intentos_d   = '0;
          timeout_d    = '0;
          alarma_pin_d = 1'b0;
        end else begin
          timeout_d = timeout_inc;
        end
      end
      StAbierta: begin
        // Llegada still high while a car passes means a second car is following.
        if (sensor_ingreso_vehiculo) begin
          inc     = 1'b1;
          state_d = sensor_llegada_vehiculo ? StBloqueo : StIdle;
        end
      end
      StBloqueo: begin
        if (clave_enter && match) begin
          state_d      = StIdle;
          intentos_d   = '0;
          alarma_pin_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dec = sensor_salida_vehiculo && !salida_prev_q && (ocupacion_q != '0);

  always_comb begin
    ocupacion_d = ocupacion_q;
    unique case ({inc, dec})
      2'b10:   if (ocupacion_q != CapOcc) ocupacion_d = ocupacion_q + OCC_W'(1);
      2'b01:   ocupacion_d = ocupacion_q - OCC_W'(1);
      default: ocupacion_d = ocupacion_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      intentos_q       <= '0;
      timeout_q        <= '0;
      ocupacion_q      <= '0;
      alarma_pin_q     <= 1'b0;
      compuerta_q      <= 1'b0;
      alarma_bloqueo_q <= 1'b0;
      lleno_q          <= 1'b0;
      salida_prev_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      intentos_q       <= intentos_d;
      timeout_q        <= timeout_d;
      ocupacion_q      <= ocupacion_d;
      alarma_pin_q     <= alarma_pin_d;
      compuerta_q      <= (state_d == StAbierta);
      alarma_bloqueo_q <= (state_d == StBloqueo);
      lleno_q          <= (ocupacion_d == CapOcc);
      salida_prev_q    <= sensor_salida_vehiculo;
    end
  end

  assign senal_compuerta      = compuerta_q;
  assign senal_alarma_pin     = alarma_pin_q;
  assign senal_alarma_bloqueo = alarma_bloqueo_q;
  assign senal_lleno          = lleno_q;
  assign ocupacion            = ocupacion_q;

endmodule

// File: tb/tb_access_ctrl_param.sv
// Directed bench for access_ctrl_param with capacity 4 and a 20-cycle timeout.
module tb_access_ctrl_param;

  logic        clock;
  logic        reset;
  logic        llegada, ingreso, salida, clave_enter;
  logic [15:0] clave;
  logic        compuerta, alarma_pin, alarma_bloqueo, lleno;
  logic [2:0]  ocupacion;

  int vectors = 0;
  int miscompares = 0;

  access_ctrl_param #(
    .CAPACIDAD     (4),
    .TIMEOUT_CICLOS(20)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .sensor_llegada_vehiculo(llegada),
    .sensor_ingreso_vehiculo(ingreso),
    .sensor_salida_vehiculo (salida),
    .clave_enter            (clave_enter),
    .clave_ingresada        (clave),
    .senal_compuerta        (compuerta),
    .senal_alarma_pin       (alarma_pin),
    .senal_alarma_bloqueo   (alarma_bloqueo),
    .senal_lleno            (lleno),
    .ocupacion              (ocupacion)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_key(input logic [15:0] k);
    clave       = k;
    clave_enter = 1'b1;
    tick();
    clave_enter = 1'b0;
  endtask

  task automatic admit();
    llegada = 1'b1;
    tick();
    enter_key(16'h1234);
    llegada = 1'b0;
    ingreso = 1'b1;
    tick();
    ingreso = 1'b0;
  endtask

  initial begin
    reset = 1'b0; llegada = 1'b0; ingreso = 1'b0; salida = 1'b0;
    clave_enter = 1'b0; clave = 16'h0000;
    tick();
    tick();
    check("rst_compuerta", compuerta, 0);
    check("rst_pin", alarma_pin, 0);
    check("rst_bloqueo", alarma_bloqueo, 0);
    check("rst_lleno", lleno, 0);
    check("rst_ocupacion", ocupacion, 0);
    reset = 1'b1;
    tick();

    // Normal admission
    llegada = 1'b1;
    tick();
    check("espera_compuerta", compuerta, 0);
    enter_key(16'h1234);
    check("abierta_compuerta", compuerta, 1);
    llegada = 1'b0;
    ingreso = 1'b1;
    tick();
    ingreso = 1'b0;
    check("pass_compuerta", compuerta, 0);
    check("pass_ocupacion", ocupacion, 1);

    // Wrong keys up to lockout, then unlock
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    enter_key(16'h0000);
    check("wrong1_pin", alarma_pin, 1);
    check("wrong1_bloqueo", alarma_bloqueo, 0);
    enter_key(16'h1111);
    check("wrong2_pin", alarma_pin, 1);
    check("wrong2_bloqueo", alarma_bloqueo, 0);
    enter_key(16'h2222);
    check("wrong3_bloqueo", alarma_bloqueo, 1);
    check("wrong3_pin", alarma_pin, 1);
    check("wrong3_compuerta", compuerta, 0);
    enter_key(16'h3333);
    check("locked_ignore", alarma_bloqueo, 1);
    enter_key(16'hBEEF);
    check("unlock_bloqueo", alarma_bloqueo, 0);
    check("unlock_pin", alarma_pin, 0);

    // Tailgate from ABIERTA
    llegada = 1'b1;
    tick();
    enter_key(16'hBEEF);
    check("tg_open", compuerta, 1);
    ingreso = 1'b1;
    tick();
    ingreso = 1'b0;
    llegada = 1'b0;
    check("tg_bloqueo", alarma_bloqueo, 1);
    check("tg_compuerta", compuerta, 0);
    check("tg_ocupacion", ocupacion, 2);
    enter_key(16'h1234);
    check("tg_unlock", alarma_bloqueo, 0);

    // Fill the lot
    admit();
    check("fill3_ocupacion", ocupacion, 3);
    check("fill3_lleno", lleno, 0);
    admit();
    check("fill4_ocupacion", ocupacion, 4);
    check("fill4_lleno", lleno, 1);
    llegada = 1'b1;
    tick();
    tick();
    enter_key(16'h1234);
    check("full_compuerta", compuerta, 0);
    llegada = 1'b0;
    salida = 1'b1;
    tick();
    check("exit_ocupacion", ocupacion, 3);
    check("exit_lleno", lleno, 0);
    tick();
    check("exit_level_once", ocupacion, 3);
    salida = 1'b0;
    tick();

    // Timeout after a wrong key
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    enter_key(16'h0000);
    check("to_pin_set", alarma_pin, 1);
    repeat (19) tick();
    check("to_pin_before", alarma_pin, 1);
    tick();
    check("to_pin_after", alarma_pin, 0);
    enter_key(16'h1234);
    check("to_idle_no_open", compuerta, 0);

    // Entry and exit on the same edge
    llegada = 1'b1;
    tick();
    enter_key(16'h1234);
    llegada = 1'b0;
    ingreso = 1'b1;
    salida  = 1'b1;
    tick();
    ingreso = 1'b0;
    check("simul_ocupacion", ocupacion, 3);
    tick();
    check("simul_hold", ocupacion, 3);
    salida = 1'b0;
    tick();

    // Asynchronous reset in BLOQUEO
    llegada = 1'b1;
    tick();
    llegada = 1'b0;
    enter_key(16'h0001);
    enter_key(16'h0002);
    enter_key(16'h0003);
    check("pre_rst_bloqueo", alarma_bloqueo, 1);
    check("pre_rst_ocupacion", ocupacion, 3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_compuerta", compuerta, 0);
    check("arst_pin", alarma_pin, 0);
    check("arst_bloqueo", alarma_bloqueo, 0);
    check("arst_lleno", lleno, 0);
    check("arst_ocupacion", ocupacion, 0);
    tick();
    reset = 1'b1;
    tick();

    // Exit with an empty lot
    salida = 1'b1;
    tick();
    check("empty_exit", ocupacion, 0);
    salida = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
